// File: rtl/regfile_fwd_if.sv
// Bus bundle for regfile_fwd: writeback, read ports, forwarding sources,
// issue/scoreboard control, stall status and debug read.
// The master modport drives the requests; the register file uses the slave modport.
interface regfile_fwd_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NFWD = 3
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic                 wen;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD*AW-1:0]   fwd_addr;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NFWD-1:0]      fwd_ready;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic                 issue_is_load;
    logic                 flush;
    logic [NRD-1:0]       hazard;
    logic                 stall;
    logic [31:0]          stall_cnt;
    logic [AW-1:0]        dbg_addr;
    logic [XLEN-1:0]      dbg_data;

    modport master (
        output wen, waddr, wdata, rd_addr, fwd_valid, fwd_addr, fwd_data, fwd_ready,
               issue_valid, issue_rd, issue_is_load, flush, dbg_addr,
        input  rd_data, hazard, stall, stall_cnt, dbg_data
    );

    modport slave (
        input  wen, waddr, wdata, rd_addr, fwd_valid, fwd_addr, fwd_data, fwd_ready,
               issue_valid, issue_rd, issue_is_load, flush, dbg_addr,
        output rd_data, hazard, stall, stall_cnt, dbg_data
    );
endinterface

// File: rtl/regfile_fwd.sv
// Register file with priority operand forwarding, write-through, hazard
// detection and a saturating stall counter.
// Optional feature: define REGFILE_SCOREBOARD_EN to keep a per-register busy
// bit for outstanding loads; without it issue_* and flush are ignored.
module regfile_fwd #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NFWD = 3
) (
    input  logic          clk,
    input  logic          rst,
    regfile_fwd_if.slave  bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0]     regs [NREG];
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      hazard_c;
    logic                stall_c;
    logic [31:0]         stall_cnt_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0]     busy_q;
`endif

    // Array write; register 0 is hardwired to zero and never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else if (bus.wen && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Read ports: zero, then youngest matching forward source, then write-through, then array.
    always_comb begin
        rd_data_c = '0;
        hazard_c  = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   addr;
            logic            found;
            logic            rdy;
            logic            wthru;
            logic [XLEN-1:0] fdata;
            logic [XLEN-1:0] val;
            addr  = bus.rd_addr[i*AW +: AW];
            found = 1'b0;
            rdy   = 1'b0;
            fdata = '0;
            // A not-ready young source shadows every older one, so stop at the first match.
            for (int k = 0; k < NFWD; k++) begin
                if (!found && bus.fwd_valid[k] && (bus.fwd_addr[k*AW +: AW] == addr)) begin
                    found = 1'b1;
                    rdy   = bus.fwd_ready[k];
                    fdata = bus.fwd_data[k*XLEN +: XLEN];
                end
            end
            wthru = !found && bus.wen && (bus.waddr == addr);
            if (addr == '0) begin
                val = '0;
            end else if (found && rdy) begin
                val = fdata;
            end else if (found) begin
                val = regs[addr];
                hazard_c[i] = 1'b1;
            end else if (wthru) begin
                val = bus.wdata;
            end else begin
                val = regs[addr];
            end
`ifdef REGFILE_SCOREBOARD_EN
            // An outstanding load is resolved only by a ready forward or the writeback itself.
            if ((addr != '0) && busy_q[addr] && !(found && rdy) && !wthru) begin
                hazard_c[i] = 1'b1;
            end
`endif
            rd_data_c[i*XLEN +: XLEN] = val;
        end
    end

    assign stall_c = |hazard_c;

    // Stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    // Busy bits for in-flight loads: flush beats set, set beats writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else if (bus.flush) begin
            busy_q <= '0;
        end else begin
            logic [NREG-1:0] nxt;
            nxt = busy_q;
            if (bus.wen) nxt[bus.waddr] = 1'b0;
            if (bus.issue_valid && bus.issue_is_load && (bus.issue_rd != '0) && !stall_c)
                nxt[bus.issue_rd] = 1'b1;
            busy_q <= nxt;
        end
    end
`endif

    assign bus.rd_data   = rd_data_c;
    assign bus.hazard    = hazard_c;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.dbg_data  = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];

endmodule
